// File: rtl/eco_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eco_pkg
// Description : Shared types and constants for the ECO result capture buffer.
//               Holds the capture FSM state encoding and the mismatch counter
//               width plus its saturating increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package eco_pkg;

  // Capture control states; encoding is fixed so it can be observed in debug.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HALT    = 2'd2
  } eco_state_e;

  // Width of the saturating mismatch counter.
  localparam int MIS_CNT_W = 8;

  // Value at which the mismatch counter stops counting.
  localparam logic [MIS_CNT_W-1:0] MIS_CNT_MAX = {MIS_CNT_W{1'b1}};

  // Saturating increment for the mismatch counter.
  function automatic logic [MIS_CNT_W-1:0] mis_cnt_inc(input logic [MIS_CNT_W-1:0] val);
    logic [MIS_CNT_W-1:0] res;
    if (val == MIS_CNT_MAX) begin
      res = val;
    end else begin
      res = val + 1'b1;
    end
    return res;
  endfunction

endpackage : eco_pkg
`default_nettype wire

// File: rtl/eco_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : eco_sync_fifo
// Description : Single-clock FIFO with power-of-two depth. Head entry is shown
//               combinationally on rdata; occupancy, full and empty are
//               registered-derived and update on the same edge as a push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module eco_sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int              AW     = $clog2(DEPTH);
  localparam logic [AW:0]     C_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A push into a full FIFO is refused even if a pop happens in the same
  // cycle, so the accept decision only looks at the current occupancy.
  assign w_push = push && (r_count != C_FULL);
  assign w_pop  = pop  && (r_count != '0);

  assign full  = (r_count == C_FULL);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rd_ptr];

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : eco_sync_fifo
`default_nettype wire

// File: rtl/eco_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : eco_result_buffer
// Description : Captures result vectors from an ECO netlist, tags each with a
//               mismatch bit against the golden value and queues them in a
//               FIFO. Capture can halt on the first mismatch; overflow and a
//               saturating mismatch count are reported.
// Revision    : 1.0 - initial release
// ============================================================================
module eco_result_buffer
  import eco_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop_on_err,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_y,
  input  logic [WIDTH-1:0]       in_exp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_mis,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [MIS_CNT_W-1:0]   mis_cnt,
  output logic                   halted
);

  eco_state_e           r_state;
  eco_state_e           w_state_nxt;
  logic                 w_capturing;
  logic                 w_mis;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_pop;
  logic                 r_overflow;
  logic [MIS_CNT_W-1:0] r_mis_cnt;
  logic [WIDTH:0]       w_head;
  logic                 w_full;
  logic                 w_empty;

  assign w_capturing = (r_state == ST_CAPTURE);
  assign w_mis       = (in_y != in_exp);
  assign w_push      = w_capturing && in_valid && !w_full;
  assign w_drop      = w_capturing && in_valid &&  w_full;
  assign w_pop       = !w_empty && out_ready;

  // Entry layout: captured vector in the upper bits, mismatch flag in bit 0.
  eco_sync_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({in_y, w_mis}),
    .rdata (w_head),
    .count (count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign full      = w_full;
  assign empty     = w_empty;
  assign out_valid = !w_empty;
  assign out_data  = w_head[WIDTH:1];
  assign out_mis   = w_head[0];
  assign overflow  = r_overflow;
  assign mis_cnt   = r_mis_cnt;
  assign halted    = (r_state == ST_HALT);

  // Capture state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: start arms capture; a stored mismatch halts it when enabled.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (w_push && w_mis && stop_on_err) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (start) begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sticky overflow flag: set by any sample refused while capturing and full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Saturating count of mismatching samples actually stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mis_cnt <= '0;
    end else if (w_push && w_mis) begin
      r_mis_cnt <= mis_cnt_inc(r_mis_cnt);
    end
  end

endmodule : eco_result_buffer
`default_nettype wire

// File: tb/tb_eco_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_eco_result_buffer
// Description : Scoreboard bench for eco_result_buffer. A reference model
//               tracks mode, occupancy and flags from the behavioural rules
//               and queues expected entries; a monitor compares DUT outputs
//               and every popped entry against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eco_result_buffer;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop_on_err = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_y = '0;
  logic [WIDTH-1:0] in_exp = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_mis;
  logic [$clog2(DEPTH):0] count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic [7:0]       mis_cnt;
  logic             halted;

  eco_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop_on_err (stop_on_err),
    .in_valid    (in_valid),
    .in_y        (in_y),
    .in_exp      (in_exp),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_mis     (out_mis),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .mis_cnt     (mis_cnt),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic             mis;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Reference model state (meaning: what the DUT holds after the last edge).
  bit  m_run  = 1'b0;
  bit  m_halt = 1'b0;
  bit  m_ovf  = 1'b0;
  int  m_count = 0;
  int  m_mis_cnt = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: compare status against the model and popped entries against the scoreboard.
  always @(negedge clk) begin
    chk("count",     int'(count),     m_count);
    chk("empty",     int'(empty),     int'(m_count == 0));
    chk("full",      int'(full),      int'(m_count == DEPTH));
    chk("out_valid", int'(out_valid), int'(m_count > 0));
    chk("overflow",  int'(overflow),  int'(m_ovf));
    chk("mis_cnt",   int'(mis_cnt),   m_mis_cnt);
    chk("halted",    int'(halted),    int'(m_halt));
    if (out_valid && out_ready && !rst) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_empty: actual out_valid 1 required no entry queued at %0t", $time);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("out_data", int'(out_data), int'(e.y));
        chk("out_mis",  int'(out_mis),  int'(e.mis));
      end
    end
  end

  // Model: apply this cycle's inputs to predict the state after the coming edge.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      m_run = 0; m_halt = 0; m_ovf = 0; m_count = 0; m_mis_cnt = 0;
      sb.delete();
    end else begin
      bit do_pop, do_push, mis;
      do_pop  = (m_count > 0) && out_ready;
      do_push = m_run && in_valid && (m_count < DEPTH);
      mis     = 1'b0;
      if (m_run && in_valid && m_count == DEPTH) m_ovf = 1;
      if (do_push) begin
        mis = (in_y != in_exp);
        sb.push_back('{in_y, mis});
        if (mis && m_mis_cnt < 255) m_mis_cnt++;
      end
      m_count = m_count + int'(do_push) - int'(do_pop);
      if (!m_run && start) begin
        m_run = 1; m_halt = 0;
      end else if (do_push && mis && stop_on_err) begin
        m_run = 0; m_halt = 1;
      end
    end
  end

  task automatic drive(input logic r, input logic s, input logic soe, input logic v,
                       input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] e, input logic rdy);
    rst = r; start = s; stop_on_err = soe; in_valid = v; in_y = y; in_exp = e; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] y;
    @(posedge clk);
    #1;
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);

    // Basic pass-through of two matching samples.
    drive(0, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 4'h5, 4'h5, 1);
    drive(0, 0, 0, 1, 4'hA, 4'hA, 1);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 1);

    // Fill past capacity with no consumer, then drain.
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) drive(0, 0, 0, 1, 4'(i + 1), 4'(i + 1), 0);
    repeat (10) drive(0, 0, 0, 0, 0, 0, 1);

    // Halt on first mismatch, then resume.
    do_reset();
    drive(0, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 4'h3, 4'h3, 0);
    drive(0, 0, 1, 1, 4'h7, 4'h6, 0);
    drive(0, 0, 1, 1, 4'h1, 4'h1, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 4'h2, 4'h2, 0);
    repeat (5) drive(0, 0, 1, 0, 0, 0, 1);

    // Mismatch counter saturation with continuous draining.
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 300; i++) begin
      y = 4'($urandom);
      drive(0, 0, 0, 1, y, ~y, 1);
    end
    repeat (2) drive(0, 0, 0, 0, 0, 0, 1);

    // Push and pop every cycle across pointer wrap.
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      y = 4'($urandom);
      drive(0, 0, 0, 1, y, y, 1);
    end
    repeat (2) drive(0, 0, 0, 0, 0, 0, 1);

    // Reset mid-capture with entries held, then samples ignored until start.
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 4'(i + 8), 4'(i), 0);
    drive(1, 1, 0, 1, 4'hF, 4'hF, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 4'(i), 4'(i), 1);
    drive(0, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 4'hC, 4'hC, 1);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 1);

    // Randomised traffic.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            4'($urandom), 4'($urandom_range(0, 1) ? $urandom : 32'(in_y)),
            1'($urandom_range(0, 2) != 0));
    end
    repeat (12) drive(0, 0, 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_eco_result_buffer
`default_nettype wire
